// File: rtl/udiv_handshake_if.sv
// Operand/result bundle for udiv_handshake.
// slave = the divider, master = the initiator that supplies A and B and acks Z.
// UDIV_HANDSHAKE_REMAINDER_EN adds the output_r remainder signal.
interface udiv_handshake_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] input_a;
  logic             input_a_stb;
  logic             input_a_ack;
  logic [WIDTH-1:0] input_b;
  logic             input_b_stb;
  logic             input_b_ack;
  logic [WIDTH-1:0] output_z;
  logic             output_z_stb;
  logic             output_z_ack;
`ifdef UDIV_HANDSHAKE_REMAINDER_EN
  logic [WIDTH-1:0] output_r;

  modport slave (
    input  input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
    output input_a_ack, input_b_ack, output_z, output_z_stb, output_r
  );
  modport master (
    output input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
    input  input_a_ack, input_b_ack, output_z, output_z_stb, output_r
  );
`else
  modport slave (
    input  input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
    output input_a_ack, input_b_ack, output_z, output_z_stb
  );
  modport master (
    output input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
    input  input_a_ack, input_b_ack, output_z, output_z_stb
  );
`endif
endinterface

// File: rtl/udiv_handshake.sv
// Unsigned restoring divider behind a/b/z strobe-ack channels.
// Takes A then B, runs WIDTH shift-subtract cycles, holds Z until acked.
// Optional: UDIV_HANDSHAKE_REMAINDER_EN registers A mod B on output_r.
module udiv_handshake #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  udiv_handshake_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {GET_A, GET_B, DIVIDE, PUT_Z} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] a_q, a_q_d, b_q, b_q_d;
  logic [WIDTH-1:0] r, r_d, q, q_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             a_ack, a_ack_d, b_ack, b_ack_d;
  logic [WIDTH-1:0] z, z_d;
  logic             z_stb, z_stb_d;
`ifdef UDIV_HANDSHAKE_REMAINDER_EN
  logic [WIDTH-1:0] r_out, r_out_d;
`endif

  // One restoring step. The partial remainder is always < divisor (or a prefix
  // of A when B=0), so it fits WIDTH bits; only the trial value t needs WIDTH+1,
  // and the low WIDTH bits of t-b_q are exact whenever t >= b_q.
  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH-1:0] r_step, q_step;
  assign t      = {r, q[WIDTH-1]};
  assign ge     = (t >= {1'b0, b_q});
  assign r_step = ge ? (t[WIDTH-1:0] - b_q) : t[WIDTH-1:0];
  assign q_step = {q[WIDTH-2:0], ge};

  // Next-state and next-output selection; every register holds by default.
  always_comb begin
    state_d = state;
    a_q_d   = a_q;
    b_q_d   = b_q;
    r_d     = r;
    q_d     = q;
    cnt_d   = cnt;
    a_ack_d = a_ack;
    b_ack_d = b_ack;
    z_d     = z;
    z_stb_d = z_stb;
`ifdef UDIV_HANDSHAKE_REMAINDER_EN
    r_out_d = r_out;
`endif
    case (state)
      GET_A: begin
        if (a_ack && bus.input_a_stb) begin
          a_q_d   = bus.input_a;
          a_ack_d = 1'b0;
          b_ack_d = 1'b1;
          state_d = GET_B;
        end else begin
          a_ack_d = 1'b1;
        end
      end
      GET_B: begin
        if (b_ack && bus.input_b_stb) begin
          b_q_d   = bus.input_b;
          b_ack_d = 1'b0;
          r_d     = '0;
          q_d     = a_q;
          cnt_d   = '0;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          z_d     = q_step;
          z_stb_d = 1'b1;
`ifdef UDIV_HANDSHAKE_REMAINDER_EN
          r_out_d = r_step;
`endif
          state_d = PUT_Z;
        end
      end
      PUT_Z: begin
        if (bus.output_z_ack) begin
          z_stb_d = 1'b0;
          a_ack_d = 1'b1;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  // State and output registers; reset clears everything, including operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GET_A;
      a_q   <= '0;
      b_q   <= '0;
      r     <= '0;
      q     <= '0;
      cnt   <= '0;
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      z     <= '0;
      z_stb <= 1'b0;
`ifdef UDIV_HANDSHAKE_REMAINDER_EN
      r_out <= '0;
`endif
    end else begin
      state <= state_d;
      a_q   <= a_q_d;
      b_q   <= b_q_d;
      r     <= r_d;
      q     <= q_d;
      cnt   <= cnt_d;
      a_ack <= a_ack_d;
      b_ack <= b_ack_d;
      z     <= z_d;
      z_stb <= z_stb_d;
`ifdef UDIV_HANDSHAKE_REMAINDER_EN
      r_out <= r_out_d;
`endif
    end
  end

  assign bus.input_a_ack  = a_ack;
  assign bus.input_b_ack  = b_ack;
  assign bus.output_z     = z;
  assign bus.output_z_stb = z_stb;
`ifdef UDIV_HANDSHAKE_REMAINDER_EN
  assign bus.output_r     = r_out;
`endif
endmodule

// File: tb/tb_udiv_handshake.sv
// Directed + randomized bench for udiv_handshake; reference is plain / and %.
module tb_udiv_handshake;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  udiv_handshake_if #(.WIDTH(W)) bus();
  udiv_handshake #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ack outputs and result strobe are mutually exclusive at all times.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert ($countones({bus.input_a_ack, bus.input_b_ack, bus.output_z_stb}) <= 1) else begin
        errors++;
        $error("FAIL onehot a_ack=%0b b_ack=%0b z_stb=%0b",
               bus.input_a_ack, bus.input_b_ack, bus.output_z_stb);
      end
    end
  end

  function automatic logic [W-1:0] ref_z(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? '1 : a / b;
  endfunction
  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  // A transfer, then B transfer; returns with the B transfer edge just passed.
  task automatic send_ab(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    bus.input_a = a;
    bus.input_a_stb = 1'b1;
    n = 0;
    while (!bus.input_a_ack && n < 100) begin tick(); n++; end
    chk("a_ack_wait", bus.input_a_ack, 1);
    tick();
    bus.input_a_stb = 1'b0;
    chk("a_ack_drop", bus.input_a_ack, 0);
    chk("b_ack_rise", bus.input_b_ack, 1);
    bus.input_b = b;
    bus.input_b_stb = 1'b1;
    n = 0;
    while (!bus.input_b_ack && n < 100) begin tick(); n++; end
    tick();
    bus.input_b_stb = 1'b0;
    chk("b_ack_drop", bus.input_b_ack, 0);
  endtask

  task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b, input int zdly);
    int lat;
    logic [W-1:0] ez;
    ez = ref_z(a, b);
    lat = 0;
    while (!bus.output_z_stb && lat < 200) begin tick(); lat++; end
    chk("latency", lat, W);
    chk("z_value", bus.output_z, ez);
`ifdef UDIV_HANDSHAKE_REMAINDER_EN
    chk("r_value", bus.output_r, ref_r(a, b));
`endif
    for (int i = 0; i < zdly; i++) begin
      tick();
      chk("z_hold_stb", bus.output_z_stb, 1);
      chk("z_hold_val", bus.output_z, ez);
      chk("z_hold_aack", bus.input_a_ack, 0);
    end
    bus.output_z_ack = 1'b1;
    tick();
    bus.output_z_ack = 1'b0;
    chk("z_stb_drop", bus.output_z_stb, 0);
    chk("a_ack_back", bus.input_a_ack, 1);
    chk("z_keep", bus.output_z, ez);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int zdly);
    send_ab(a, b);
    finish_op(a, b, zdly);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_aack"}, bus.input_a_ack, 0);
    chk({tag, "_back"}, bus.input_b_ack, 0);
    chk({tag, "_z"}, bus.output_z, 0);
    chk({tag, "_zstb"}, bus.output_z_stb, 0);
`ifdef UDIV_HANDSHAKE_REMAINDER_EN
    chk({tag, "_r"}, bus.output_r, 0);
`endif
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int n;
    bus.input_a = '0;
    bus.input_a_stb = 1'b0;
    bus.input_b = '0;
    bus.input_b_stb = 1'b0;
    bus.output_z_ack = 1'b0;

    // Reset state; B strobed from reset, A delayed 5 cycles.
    bus.input_b = 32'd2;
    bus.input_b_stb = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk("a_ack_after_rst", bus.input_a_ack, 1);
    for (int i = 0; i < 5; i++) begin
      chk("b_early_noack", bus.input_b_ack, 0);
      tick();
    end
    bus.input_a = 32'd9;
    bus.input_a_stb = 1'b1;
    chk("b_early_noack2", bus.input_b_ack, 0);
    tick();
    bus.input_a_stb = 1'b0;
    chk("b_ack_after_a", bus.input_b_ack, 1);
    tick();
    bus.input_b_stb = 1'b0;
    chk("b_ack_drop_early", bus.input_b_ack, 0);
    finish_op(32'd9, 32'd2, 1);

    // Basic and boundary operands.
    do_op(32'd100, 32'd7, 1);
    do_op(32'hFFFF_FFFF, 32'd1, 0);
    do_op(32'd6, 32'd3, 0);
    do_op(32'd7, 32'd0, 1);

    // Result withheld for 100 cycles.
    do_op(32'd12, 32'd4, 100);

    // Reset at DIVIDE cycle 10.
    send_ab(32'd50, 32'd3);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("midrst");
    tick();
    chk("midrst_aack", bus.input_a_ack, 1);
    do_op(32'd8, 32'd2, 1);

    // Randomized operations.
    for (int k = 0; k < 25; k++) begin
      ra = $urandom();
      n = $urandom_range(0, 3);
      if (n == 0) rb = '0;
      else if (n == 1) rb = W'($urandom_range(1, 15));
      else rb = $urandom() >> $urandom_range(0, 31);
      do_op(ra, rb, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
